// File: rtl/rs_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation station.
interface rs_if;
   logic        in_valid;
   logic [5:0]  in_op;
   logic [31:0] in_imm;
   logic [31:0] in_pc;
   logic [3:0]  in_rdTag;
   logic [31:0] in_Vj;
   logic        in_Qj_busy;
   logic [3:0]  in_Qj;
   logic [31:0] in_Vk;
   logic        in_Qk_busy;
   logic [3:0]  in_Qk;
   logic        alu_cdb_en;
   logic [31:0] alu_cdb_result;
   logic [3:0]  alu_cdb_tag;
   logic        lsb_cdb_en;
   logic [31:0] lsb_cdb_result;
   logic [3:0]  lsb_cdb_tag;
   logic        full;
   logic        out_valid;
   logic [5:0]  out_op;
   logic [31:0] out_Vj;
   logic [31:0] out_Vk;
   logic [31:0] out_imm;
   logic [3:0]  out_rdTag;
   logic [31:0] out_pc;

   modport master (
      output in_valid, in_op, in_imm, in_pc, in_rdTag,
             in_Vj, in_Qj_busy, in_Qj, in_Vk, in_Qk_busy, in_Qk,
             alu_cdb_en, alu_cdb_result, alu_cdb_tag,
             lsb_cdb_en, lsb_cdb_result, lsb_cdb_tag,
      input  full, out_valid, out_op, out_Vj, out_Vk, out_imm, out_rdTag, out_pc
   );
   modport slave (
      input  in_valid, in_op, in_imm, in_pc, in_rdTag,
             in_Vj, in_Qj_busy, in_Qj, in_Vk, in_Qk_busy, in_Qk,
             alu_cdb_en, alu_cdb_result, alu_cdb_tag,
             lsb_cdb_en, lsb_cdb_result, lsb_cdb_tag,
      output full, out_valid, out_op, out_Vj, out_Vk, out_imm, out_rdTag, out_pc
   );
endinterface

// File: rtl/reservation_station.sv
// ALU reservation station: snoops two CDBs, issues lowest-index ready entry per cycle.
// Optional RS_BYPASS_EN: a resolved dispatch with nothing ready goes straight to out_*.
module reservation_station #(
   parameter int RS_SIZE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   input  logic clear,
   rs_if.slave  rs
);
   localparam int         IW     = $clog2(RS_SIZE);
   localparam logic [5:0] OP_NOP = 6'd0;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] vj;
      logic        qj_busy;
      logic [3:0]  qj;
      logic [31:0] vk;
      logic        qk_busy;
      logic [3:0]  qk;
      logic [31:0] imm;
      logic [3:0]  rd_tag;
      logic [31:0] pc;
   } entry_t;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [31:0] imm;
      logic [3:0]  rd_tag;
      logic [31:0] pc;
   } out_t;

   logic [RS_SIZE-1:0] busy_q, busy_d, ready;
   entry_t             ent_q [RS_SIZE];
   entry_t             ent_d [RS_SIZE];
   out_t               out_q, out_d;
   entry_t             disp;
   logic               iss_found, free_found, disp_ok, byp;
   logic [IW-1:0]      iss_idx, free_idx;

   // ALU bus is checked first so it wins when both buses carry the same tag.
   function automatic entry_t snoop(entry_t e,
                                    logic ae, logic [3:0] at, logic [31:0] ar,
                                    logic le, logic [3:0] lt, logic [31:0] lr);
      entry_t r = e;
      if (e.qj_busy && ae && at == e.qj)      begin r.qj_busy = 1'b0; r.vj = ar; end
      else if (e.qj_busy && le && lt == e.qj) begin r.qj_busy = 1'b0; r.vj = lr; end
      if (e.qk_busy && ae && at == e.qk)      begin r.qk_busy = 1'b0; r.vk = ar; end
      else if (e.qk_busy && le && lt == e.qk) begin r.qk_busy = 1'b0; r.vk = lr; end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++)
         ready[i] = busy_q[i] && !ent_q[i].qj_busy && !ent_q[i].qk_busy;
   end

   always_comb begin
      busy_d     = busy_q;
      out_d      = '0;
      iss_found  = 1'b0;
      iss_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      byp        = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!iss_found && ready[i]) begin
            iss_found = 1'b1;
            iss_idx   = IW'(i);
         end
         if (!free_found && !busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end

      disp = snoop('{op: rs.in_op, vj: rs.in_Vj, qj_busy: rs.in_Qj_busy, qj: rs.in_Qj,
                     vk: rs.in_Vk, qk_busy: rs.in_Qk_busy, qk: rs.in_Qk,
                     imm: rs.in_imm, rd_tag: rs.in_rdTag, pc: rs.in_pc},
                   rs.alu_cdb_en, rs.alu_cdb_tag, rs.alu_cdb_result,
                   rs.lsb_cdb_en, rs.lsb_cdb_tag, rs.lsb_cdb_result);

      for (int i = 0; i < RS_SIZE; i++)
         ent_d[i] = busy_q[i] ? snoop(ent_q[i],
                                      rs.alu_cdb_en, rs.alu_cdb_tag, rs.alu_cdb_result,
                                      rs.lsb_cdb_en, rs.lsb_cdb_tag, rs.lsb_cdb_result)
                              : ent_q[i];

      disp_ok = rs.in_valid && (rs.in_op != OP_NOP);
`ifdef RS_BYPASS_EN
      byp = disp_ok && !iss_found && !disp.qj_busy && !disp.qk_busy;
`else
      byp = 1'b0;
`endif

      if (iss_found) begin
         out_d = '{valid: 1'b1, op: ent_q[iss_idx].op, vj: ent_q[iss_idx].vj,
                   vk: ent_q[iss_idx].vk, imm: ent_q[iss_idx].imm,
                   rd_tag: ent_q[iss_idx].rd_tag, pc: ent_q[iss_idx].pc};
         busy_d[iss_idx] = 1'b0;
      end else if (byp) begin
         out_d = '{valid: 1'b1, op: disp.op, vj: disp.vj, vk: disp.vk,
                   imm: disp.imm, rd_tag: disp.rd_tag, pc: disp.pc};
      end

      // free_idx comes from registered busy, so a slot issued this cycle is not reused yet.
      if (disp_ok && free_found && !byp) begin
         busy_d[free_idx] = 1'b1;
         ent_d[free_idx]  = disp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
         out_q  <= '0;
      end else if (rdy) begin
         if (clear) begin
            busy_q <= '0;
            out_q  <= '0;
         end else begin
            busy_q <= busy_d;
            ent_q  <= ent_d;
            out_q  <= out_d;
         end
      end
   end

   assign rs.full      = &busy_q;
   assign rs.out_valid = out_q.valid;
   assign rs.out_op    = out_q.op;
   assign rs.out_Vj    = out_q.vj;
   assign rs.out_Vk    = out_q.vk;
   assign rs.out_imm   = out_q.imm;
   assign rs.out_rdTag = out_q.rd_tag;
   assign rs.out_pc    = out_q.pc;
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic against a slot-list model.
module tb_reservation_station;
   localparam int N = 8;
   localparam logic [5:0] ADD = 6'd1, SUB = 6'd2;

   logic clk = 1'b0, rst, rdy, clear;
   rs_if rsif();

   reservation_station #(.RS_SIZE(N)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .rs(rsif)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit        busy;
      bit [5:0]  op;
      bit [31:0] vj;
      bit        qjb;
      bit [3:0]  qj;
      bit [31:0] vk;
      bit        qkb;
      bit [3:0]  qk;
      bit [31:0] imm;
      bit [3:0]  tag;
      bit [31:0] pc;
   } ment_t;

   typedef struct packed {
      bit        valid;
      bit [5:0]  op;
      bit [31:0] vj;
      bit [31:0] vk;
      bit [31:0] imm;
      bit [3:0]  tag;
      bit [31:0] pc;
   } mout_t;

   ment_t m [N];
   mout_t mo;
   int    n_cmp = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic ment_t resolve(ment_t e);
      ment_t r = e;
      if (e.qjb && rsif.alu_cdb_en && rsif.alu_cdb_tag == e.qj) begin r.qjb = 0; r.vj = rsif.alu_cdb_result; end
      else if (e.qjb && rsif.lsb_cdb_en && rsif.lsb_cdb_tag == e.qj) begin r.qjb = 0; r.vj = rsif.lsb_cdb_result; end
      if (e.qkb && rsif.alu_cdb_en && rsif.alu_cdb_tag == e.qk) begin r.qkb = 0; r.vk = rsif.alu_cdb_result; end
      else if (e.qkb && rsif.lsb_cdb_en && rsif.lsb_cdb_tag == e.qk) begin r.qkb = 0; r.vk = rsif.lsb_cdb_result; end
      return r;
   endfunction

   // One clock of the architectural rules, applied to the model before the edge.
   task automatic model_step();
      ment_t inc;
      int    pick, slot;
      bit    ok, byp;
      if (rst) begin
         for (int i = 0; i < N; i++) m[i].busy = 0;
         mo = '0;
         return;
      end
      if (!rdy) return;
      if (clear) begin
         for (int i = 0; i < N; i++) m[i].busy = 0;
         mo = '0;
         return;
      end
      pick = -1;
      slot = -1;
      for (int i = 0; i < N; i++) begin
         if (pick < 0 && m[i].busy && !m[i].qjb && !m[i].qkb) pick = i;
         if (slot < 0 && !m[i].busy) slot = i;
      end
      inc = '{busy: 1, op: rsif.in_op, vj: rsif.in_Vj, qjb: rsif.in_Qj_busy, qj: rsif.in_Qj,
              vk: rsif.in_Vk, qkb: rsif.in_Qk_busy, qk: rsif.in_Qk, imm: rsif.in_imm,
              tag: rsif.in_rdTag, pc: rsif.in_pc};
      inc = resolve(inc);
      for (int i = 0; i < N; i++) if (m[i].busy) m[i] = resolve(m[i]);
      ok  = rsif.in_valid && rsif.in_op != 6'd0;
      byp = 0;
`ifdef RS_BYPASS_EN
      byp = ok && pick < 0 && !inc.qjb && !inc.qkb;
`endif
      mo = '0;
      if (pick >= 0) begin
         mo = '{valid: 1, op: m[pick].op, vj: m[pick].vj, vk: m[pick].vk,
                imm: m[pick].imm, tag: m[pick].tag, pc: m[pick].pc};
         m[pick].busy = 0;
      end else if (byp) begin
         mo = '{valid: 1, op: inc.op, vj: inc.vj, vk: inc.vk, imm: inc.imm, tag: inc.tag, pc: inc.pc};
      end
      if (ok && !byp && slot >= 0) m[slot] = inc;
   endtask

   task automatic tick();
      bit full_exp;
      model_step();
      @(posedge clk);
      #1;
      full_exp = 1;
      for (int i = 0; i < N; i++) if (!m[i].busy) full_exp = 0;
      chk("full",      32'(rsif.full),      32'(full_exp));
      chk("out_valid", 32'(rsif.out_valid), 32'(mo.valid));
      chk("out_op",    32'(rsif.out_op),    32'(mo.op));
      chk("out_Vj",    rsif.out_Vj,         mo.vj);
      chk("out_Vk",    rsif.out_Vk,         mo.vk);
      chk("out_imm",   rsif.out_imm,        mo.imm);
      chk("out_rdTag", 32'(rsif.out_rdTag), 32'(mo.tag));
      chk("out_pc",    rsif.out_pc,         mo.pc);
   endtask

   task automatic idle();
      rst = 0; rdy = 1; clear = 0;
      rsif.in_valid = 0; rsif.in_op = 0; rsif.in_imm = 0; rsif.in_pc = 0; rsif.in_rdTag = 0;
      rsif.in_Vj = 0; rsif.in_Qj_busy = 0; rsif.in_Qj = 0;
      rsif.in_Vk = 0; rsif.in_Qk_busy = 0; rsif.in_Qk = 0;
      rsif.alu_cdb_en = 0; rsif.alu_cdb_result = 0; rsif.alu_cdb_tag = 0;
      rsif.lsb_cdb_en = 0; rsif.lsb_cdb_result = 0; rsif.lsb_cdb_tag = 0;
   endtask

   task automatic disp(input logic [5:0] op, input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                       input logic [31:0] vk, input logic qkb, input logic [3:0] qk, input logic [3:0] tag);
      rsif.in_valid = 1; rsif.in_op = op; rsif.in_rdTag = tag;
      rsif.in_Vj = vj; rsif.in_Qj_busy = qjb; rsif.in_Qj = qj;
      rsif.in_Vk = vk; rsif.in_Qk_busy = qkb; rsif.in_Qk = qk;
      rsif.in_imm = $urandom; rsif.in_pc = $urandom;
   endtask

   task automatic no_disp();
      rsif.in_valid = 0;
      rsif.in_op    = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      rst = 0;

      // ADD 5+7, tag 3
      disp(ADD, 5, 0, 0, 7, 0, 0, 3);
      tick();
      no_disp();
`ifndef RS_BYPASS_EN
      tick();
`endif
      chk("add_valid", 32'(rsif.out_valid), 1);
      chk("add_vj",    rsif.out_Vj, 5);
      chk("add_vk",    rsif.out_Vk, 7);
      chk("add_tag",   32'(rsif.out_rdTag), 3);
      tick(); tick();

      // SUB waiting on tag 2, ALU broadcasts three cycles later
      disp(SUB, 0, 1, 2, 1, 0, 0, 4);
      tick(); no_disp(); tick(); tick();
      rsif.alu_cdb_en = 1; rsif.alu_cdb_tag = 2; rsif.alu_cdb_result = 10;
      tick();
      rsif.alu_cdb_en = 0;
      tick();
      chk("sub_valid", 32'(rsif.out_valid), 1);
      chk("sub_vj",    rsif.out_Vj, 10);
      tick();

      // Qk captured from LSB bus in the dispatch cycle
      disp(ADD, 1, 0, 0, 0, 1, 6, 5);
      rsif.lsb_cdb_en = 1; rsif.lsb_cdb_tag = 6; rsif.lsb_cdb_result = 32'hDEADBEEF;
      tick();
      no_disp(); rsif.lsb_cdb_en = 0;
      tick(); tick();

      // Fill all entries waiting on tag 9, drop a 9th, then broadcast
      for (int i = 0; i < N + 1; i++) begin
         disp(ADD, 0, 1, 9, 32'(i), 0, 0, 4'(i));
         tick();
      end
      no_disp();
      chk("fill_full", 32'(rsif.full), 1);
      rsif.alu_cdb_en = 1; rsif.alu_cdb_tag = 9; rsif.alu_cdb_result = 32'h99;
      tick();
      rsif.alu_cdb_en = 0;
      for (int i = 0; i < N + 2; i++) tick();

      // Four waiting entries flushed, later broadcast must issue nothing
      for (int i = 0; i < 4; i++) begin
         disp(SUB, 0, 1, 9, 0, 0, 0, 4'(i));
         tick();
      end
      no_disp(); clear = 1;
      tick();
      clear = 0;
      chk("clr_full", 32'(rsif.full), 0);
      rsif.alu_cdb_en = 1; rsif.alu_cdb_tag = 9;
      tick();
      rsif.alu_cdb_en = 0;
      tick(); tick();

      // Stall mid-stream: rdy low for three cycles with live inputs
      for (int i = 0; i < 3; i++) begin
         disp(ADD, $urandom, 0, 0, $urandom, 0, 0, 4'(i + 8));
         tick();
      end
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         disp(SUB, $urandom, 0, 0, $urandom, 0, 0, 4'(i));
         rsif.alu_cdb_en = 1; rsif.alu_cdb_tag = 4'(i);
         tick();
      end
      rdy = 1; no_disp(); rsif.alu_cdb_en = 0;
      for (int i = 0; i < 5; i++) tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 199) == 0);
         clear = ($urandom_range(0, 39) == 0);
         rdy   = ($urandom_range(0, 9) != 0);
         rsif.in_valid   = ($urandom_range(0, 9) < 6);
         rsif.in_op      = 6'($urandom_range(0, 3));
         rsif.in_imm     = $urandom;
         rsif.in_pc      = $urandom;
         rsif.in_rdTag   = 4'($urandom);
         rsif.in_Vj      = $urandom;
         rsif.in_Qj_busy = 1'($urandom);
         rsif.in_Qj      = 4'($urandom_range(0, 3));
         rsif.in_Vk      = $urandom;
         rsif.in_Qk_busy = 1'($urandom);
         rsif.in_Qk      = 4'($urandom_range(0, 3));
         rsif.alu_cdb_en     = ($urandom_range(0, 9) < 4);
         rsif.alu_cdb_tag    = 4'($urandom_range(0, 3));
         rsif.alu_cdb_result = $urandom;
         rsif.lsb_cdb_en     = ($urandom_range(0, 9) < 4);
         rsif.lsb_cdb_tag    = 4'($urandom_range(0, 3));
         rsif.lsb_cdb_result = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  in  1  global enable; low freezes all state and outputs.
REQ-005 SHALL have port clear  in  1  mispredict flush.
REQ-006 SHALL have port full  out  1  no free entry.
REQ-007 SHALL have ports in_valid/in_op/in_imm/in_pc/in_rdTag  in  1/6/32/32/4  dispatched instruction; tag width per `ROBRange (4).
REQ-008 SHALL have ports in_Vj/in_Qj_busy/in_Qj and in_Vk/in_Qk_busy/in_Qk  in  32/1/4 each  operand value or producer tag.
REQ-009 SHALL have ports alu_cdb_en/alu_cdb_result/alu_cdb_tag and lsb_cdb_en/lsb_cdb_result/lsb_cdb_tag  in  1/32/4 each  snooped buses.
REQ-010 SHALL have ports out_valid/out_op/out_Vj/out_Vk/out_imm/out_rdTag/out_pc  out  1/6/32/32/32/4/32  registered issue to ALU.

Function
REQ-011 Per entry SHALL hold busy, op, Vj, Qj_busy, Qj, Vk, Qk_busy, Qk, imm, rdTag, pc.
REQ-012 full SHALL be combinational: 1 iff all RS_SIZE entries busy.
REQ-013 in_valid=1, full=0, in_op!=`NOP SHALL write lowest-index free entry at the edge; in_valid with full=1 or in_op=`NOP SHALL be ignored, no state change.
REQ-014 Dispatch-cycle capture: pending operand whose tag matches an asserted CDB tag in that cycle SHALL be stored resolved with the CDB value.
REQ-015 Snoop: each cycle every busy entry with pending Qj/Qk matching an enabled CDB tag SHALL capture result and clear pending; both buses SHALL be checked in parallel; ALU bus wins if both match (illegal, still defined).
REQ-016 Entry ready = busy and both operands resolved, evaluated on registered state.
REQ-017 Each cycle lowest-index ready entry SHALL be issued: out_* loaded at next edge, entry freed same edge; at most one issue per cycle.
REQ-018 No ready entry: out_valid SHALL be 0 next cycle; out_* data then don't-care but SHALL be 0.
REQ-019 No backpressure: ALU consumes out_* in the cycle out_valid=1.
REQ-020 Latency (without bypass): dispatch with both operands resolved at edge E -> out_valid in cycle after edge E+1.
REQ-021 Same-cycle dispatch and issue SHALL be allowed; slot freed by issue SHALL NOT be reused until next cycle.
REQ-022 clear=1 SHALL invalidate all entries and force out_valid=0 at the edge; it overrides dispatch, issue, snoop.
REQ-023 rdy=0 SHALL hold all entries and out_* unchanged, ignore dispatch and CDB.
REQ-024 rdTag and op SHALL pass unmodified; imm/pc SHALL NOT be altered.

Reset
REQ-025 rst=1 at edge SHALL clear all busy bits and set every out_* to 0; full=0 afterwards.
REQ-026 rst SHALL override clear, rdy and dispatch; reset mid-operation discards all entries.

Configuration
REQ-027 Macro RS_BYPASS_EN defined: dispatched instruction resolved at dispatch (incl. REQ-014) with no ready entry in the station SHALL load out_* directly at that edge, no entry allocated (1-cycle latency); allowed even when full=1.
REQ-028 RS_BYPASS_EN undefined: every instruction SHALL pass through an entry (REQ-020).

Verification
REQ-029 Dispatch ADD Vj=5, Vk=7, both resolved, tag 3 -> out_valid, out_op=ADD, Vj=5, Vk=7, rdTag=3 two cycles later (one with RS_BYPASS_EN).
REQ-030 Dispatch SUB Qj=2 busy, Vk=1; three cycles later alu_cdb_en, tag 2, result 10 -> out_valid next cycle with Vj=10.
REQ-031 Dispatch with Qk=6 busy while lsb_cdb tag 6, result 0xDEADBEEF same cycle -> issued with Vk=0xDEADBEEF, no further wait.
REQ-032 Fill 8 entries all waiting on tag 9 -> full=1, 9th dispatch dropped; broadcast tag 9 -> issue indices 0..7 on 8 consecutive cycles, full drops after first issue.
REQ-033 4 busy entries, clear=1 -> next cycle out_valid=0, full=0, no later issue; rdy=0 for 3 cycles mid-stream -> out_* held, no entry lost.
